// File: rtl/mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_ctrl                                                      |
// | Brief    : Byte-serial RAM port shared by instruction fetch and MEM ops   |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        io_buffer_full_in,
    input  logic        if_req_in,
    input  logic [31:0] if_addr_in,
    input  logic        if_cancel_in,
    output logic        if_done_out,
    output logic [31:0] if_inst_out,
    input  logic        mem_req_in,
    input  logic        mem_we_in,
    input  logic [31:0] mem_addr_in,
    input  logic [1:0]  mem_width_in,
    input  logic [31:0] mem_wdata_in,
    output logic        mem_done_out,
    output logic [31:0] mem_rdata_out,
    output logic        mc_busy_out,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_owner_mem;
    logic [31:0] r_base;
    logic [31:0] r_wdata;
    logic [31:0] r_buf;
    logic [2:0]  r_n;
    logic [2:0]  r_cnt;

    logic        w_grant_mem;
    logic        w_grant_if;
    logic        w_finish;
    logic        w_issue;
    logic        w_cancel;
    logic        w_stall;
    logic        w_grant_stall;
    logic [2:0]  w_n_req;
    logic [1:0]  w_cap_idx;
    logic [7:0]  w_wbyte;
    logic [31:0] w_byte_addr;
    logic [31:0] w_buf_nxt;

    // r_cnt is the index of the next byte address to issue; reads capture
    // two edges behind the address because the RAM has one cycle of latency.
    assign w_byte_addr   = r_base + {29'd0, r_cnt};
    assign w_cap_idx     = r_cnt[1:0] - 2'd2;
    assign w_wbyte       = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
    assign w_n_req       = (mem_width_in == 2'b00) ? 3'd1 :
                           (mem_width_in == 2'b01) ? 3'd2 : 3'd4;
    assign w_stall       = io_buffer_full_in && (w_byte_addr[17:16] == 2'b11);
    assign w_grant_stall = io_buffer_full_in && (mem_addr_in[17:16] == 2'b11);
    assign mc_busy_out   = mem_req_in || ((r_state != S_IDLE) && r_owner_mem);

    always_comb begin
        w_buf_nxt = r_buf;
        w_buf_nxt[{w_cap_idx, 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_mem = 1'b0;
        w_grant_if  = 1'b0;
        w_finish    = 1'b0;
        w_issue     = 1'b0;
        w_cancel    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!if_done_out && !mem_done_out) begin
                    if (mem_req_in) begin
                        w_grant_mem = 1'b1;
                        w_state_nxt = mem_we_in ? S_WRITE : S_READ;
                    end else if (if_req_in && !if_cancel_in) begin
                        w_grant_if  = 1'b1;
                        w_state_nxt = S_READ;
                    end
                end
            end
            S_READ: begin
                if (!r_owner_mem && if_cancel_in) begin
                    w_cancel    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == r_n + 3'd1) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WRITE: begin
                if (r_cnt == r_n) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (!w_stall) begin
                    w_issue = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_n           <= '0;
            r_owner_mem   <= 1'b0;
            r_base        <= '0;
            r_wdata       <= '0;
            r_buf         <= '0;
            mem_a         <= '0;
            mem_dout      <= '0;
            mem_wr        <= 1'b0;
            if_done_out   <= 1'b0;
            mem_done_out  <= 1'b0;
            if_inst_out   <= '0;
            mem_rdata_out <= '0;
        end else if (rdy_in) begin
            r_state      <= w_state_nxt;
            if_done_out  <= 1'b0;
            mem_done_out <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_mem || w_grant_if) begin
                        r_owner_mem <= w_grant_mem;
                        r_base      <= w_grant_mem ? mem_addr_in : if_addr_in;
                        r_n         <= w_grant_mem ? w_n_req : 3'd4;
                        r_wdata     <= mem_wdata_in;
                        r_buf       <= '0;
                        mem_a       <= w_grant_mem ? mem_addr_in : if_addr_in;
                        r_cnt       <= 3'd1;
                        mem_wr      <= 1'b0;
                        if (w_grant_mem && mem_we_in) begin
                            // The grant edge is already the first byte-issue edge.
                            if (w_grant_stall) begin
                                r_cnt <= 3'd0;
                            end else begin
                                mem_dout <= mem_wdata_in[7:0];
                                mem_wr   <= 1'b1;
                            end
                        end
                    end
                end
                S_READ: begin
                    mem_wr <= 1'b0;
                    if (w_cancel) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt < r_n) mem_a <= w_byte_addr;
                        if (r_cnt >= 3'd2) r_buf <= w_buf_nxt;
                        if (w_finish) begin
                            r_cnt <= '0;
                            if (r_owner_mem) begin
                                mem_rdata_out <= w_buf_nxt;
                                mem_done_out  <= 1'b1;
                            end else begin
                                if_inst_out <= w_buf_nxt;
                                if_done_out <= 1'b1;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    if (w_finish) begin
                        mem_wr       <= 1'b0;
                        mem_done_out <= 1'b1;
                        r_cnt        <= '0;
                    end else if (w_issue) begin
                        mem_a    <= w_byte_addr;
                        mem_dout <= w_wbyte;
                        mem_wr   <= 1'b1;
                        r_cnt    <= r_cnt + 3'd1;
                    end else begin
                        mem_wr <= 1'b0;
                    end
                end
                default: begin
                    r_cnt  <= '0;
                    mem_wr <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_ctrl                                                   |
// | Brief    : Directed and randomized checks of mem_ctrl against a RAM model |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, io_buffer_full_in;
    logic        if_req_in, if_cancel_in, if_done_out;
    logic [31:0] if_addr_in, if_inst_out;
    logic        mem_req_in, mem_we_in, mem_done_out, mc_busy_out;
    logic [31:0] mem_addr_in, mem_wdata_in, mem_rdata_out;
    logic [1:0]  mem_width_in;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ram [bit [31:0]];
    logic [7:0] sh  [bit [31:0]];

    mem_ctrl u_dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .io_buffer_full_in (io_buffer_full_in),
        .if_req_in         (if_req_in),
        .if_addr_in        (if_addr_in),
        .if_cancel_in      (if_cancel_in),
        .if_done_out       (if_done_out),
        .if_inst_out       (if_inst_out),
        .mem_req_in        (mem_req_in),
        .mem_we_in         (mem_we_in),
        .mem_addr_in       (mem_addr_in),
        .mem_width_in      (mem_width_in),
        .mem_wdata_in      (mem_wdata_in),
        .mem_done_out      (mem_done_out),
        .mem_rdata_out     (mem_rdata_out),
        .mc_busy_out       (mc_busy_out),
        .mem_din           (mem_din),
        .mem_dout          (mem_dout),
        .mem_a             (mem_a),
        .mem_wr            (mem_wr)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : dflt(a);
    endfunction

    function automatic logic [7:0] sh_rd(input logic [31:0] a);
        return sh.exists(a) ? sh[a] : dflt(a);
    endfunction

    // Synchronous RAM with one cycle of read latency, frozen together with the core.
    always @(posedge clk_in) begin
        if (rdy_in) begin
            mem_din <= ram_rd(mem_a);
            if (mem_wr) ram[mem_a] = mem_dout;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        ram[a] = d;
        sh[a]  = d;
    endtask

    // One transfer measured in active (rdy=1) edges from the grant edge.
    task automatic xfer(input bit is_if, input bit we, input logic [31:0] addr,
                        input logic [1:0] width, input logic [31:0] wdata, input bit rnd);
        int n, lat, act;
        bit granted, seen, rprev;
        logic [31:0] exp_v, a;
        logic [7:0] b;
        n   = is_if ? 4 : (width == 2'b00) ? 1 : (width == 2'b01) ? 2 : 4;
        lat = we ? n : n + 1;
        exp_v = '0;
        for (int k = 0; k < n; k++) begin
            a = addr + 32'(k);
            exp_v = exp_v | (32'(sh_rd(a)) << (8 * k));
        end
        if (is_if) begin
            if_req_in  = 1'b1;
            if_addr_in = addr;
        end else begin
            mem_req_in   = 1'b1;
            mem_we_in    = we;
            mem_addr_in  = addr;
            mem_width_in = width;
            mem_wdata_in = wdata;
        end
        #1;
        if (!is_if) check("busy_req", 32'(mc_busy_out), 32'd1);
        granted = 1'b0;
        seen    = 1'b0;
        act     = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            rprev = rdy_in;
            tick();
            if (rprev) begin
                if (granted) act++;
                else begin
                    granted    = 1'b1;
                    if_req_in  = 1'b0;
                    mem_req_in = 1'b0;
                end
            end
            if (granted) begin
                if (act < lat) begin
                    check("done_early", 32'(is_if ? if_done_out : mem_done_out), 32'd0);
                    if (!is_if) check("busy_xfer", 32'(mc_busy_out), 32'd1);
                end else begin
                    seen = 1'b1;
                    check("done", 32'(is_if ? if_done_out : mem_done_out), 32'd1);
                    if (!we) check("rdata", is_if ? if_inst_out : mem_rdata_out, exp_v);
                end
            end
            if (rnd) rdy_in = ($urandom_range(0, 3) != 0);
        end
        if (!seen) check("xfer_timeout", 32'd0, 32'd1);
        rdy_in = 1'b0;
        tick();
        if (seen) check("done_stretch", 32'(is_if ? if_done_out : mem_done_out), 32'd1);
        rdy_in = 1'b1;
        tick();
        check("done_clear", 32'(is_if ? if_done_out : mem_done_out), 32'd0);
        check("wr_idle", 32'(mem_wr), 32'd0);
        if (we) begin
            for (int k = 0; k < n; k++) begin
                a = addr + 32'(k);
                b = 8'(wdata >> (8 * k));
                sh[a] = b;
                check("ram_byte", 32'(ram_rd(a)), 32'(b));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ea [7];
        logic [7:0]  ed [4];
        logic [31:0] e, inst_before, ra;
        int kind;

        rst_in = 1'b1; rdy_in = 1'b0; io_buffer_full_in = 1'b0;
        if_req_in = 1'b0; if_addr_in = '0; if_cancel_in = 1'b0;
        mem_req_in = 1'b0; mem_we_in = 1'b0; mem_addr_in = '0;
        mem_width_in = 2'b00; mem_wdata_in = '0;
        repeat (3) tick();
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_dout", 32'(mem_dout), 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_if_done", 32'(if_done_out), 32'd0);
        check("rst_mem_done", 32'(mem_done_out), 32'd0);
        check("rst_inst", if_inst_out, 32'd0);
        check("rst_rdata", mem_rdata_out, 32'd0);
        check("rst_busy", 32'(mc_busy_out), 32'd0);
        rst_in = 1'b0; rdy_in = 1'b1;
        tick();

        // IF fetch of 0x100 holding 13 05 00 00.
        poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
        if_req_in = 1'b1; if_addr_in = 32'h100;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 0) if_req_in = 1'b0;
            if (k < 4) check("fetch_addr", mem_a, 32'h100 + 32'(k));
            check("fetch_wr", 32'(mem_wr), 32'd0);
            check("fetch_done", 32'(if_done_out), (k == 5) ? 32'd1 : 32'd0);
        end
        check("fetch_inst", if_inst_out, 32'h0000_0513);
        tick();
        check("fetch_done_pulse", 32'(if_done_out), 32'd0);

        // Simultaneous requests: MEM word store wins, IF waits for IDLE.
        ea = '{32'h1000, 32'h1001, 32'h1002, 32'h1003, 32'h1003, 32'h1003, 32'h200};
        ed = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        e = '0;
        for (int k = 0; k < 4; k++) e = e | (32'(sh_rd(32'h200 + 32'(k))) << (8 * k));
        mem_req_in = 1'b1; mem_we_in = 1'b1; mem_addr_in = 32'h1000;
        mem_width_in = 2'b10; mem_wdata_in = 32'hDEAD_BEEF;
        if_req_in = 1'b1; if_addr_in = 32'h200;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k == 0) mem_req_in = 1'b0;
            if (k == 6) if_req_in = 1'b0;
            if (k < 7) begin
                check("arb_addr", mem_a, ea[k]);
                check("arb_wr", 32'(mem_wr), (k < 4) ? 32'd1 : 32'd0);
                if (k < 4) check("arb_dout", 32'(mem_dout), 32'(ed[k]));
                check("arb_mem_done", 32'(mem_done_out), (k == 4) ? 32'd1 : 32'd0);
            end
            check("arb_if_done", 32'(if_done_out), (k == 11) ? 32'd1 : 32'd0);
        end
        check("arb_inst", if_inst_out, e);
        for (int k = 0; k < 4; k++) begin
            sh[32'h1000 + 32'(k)] = ed[k];
            check("arb_ram", 32'(ram_rd(32'h1000 + 32'(k))), 32'(ed[k]));
        end
        tick();

        // MEM byte load, zero-extended.
        poke(32'h0001_FFFF, 8'h80);
        xfer(1'b0, 1'b0, 32'h0001_FFFF, 2'b00, 32'd0, 1'b0);

        // IF fetch aborted by a jump; MEM request right behind it.
        inst_before = if_inst_out;
        if_req_in = 1'b1; if_addr_in = 32'h300;
        tick();
        if_req_in = 1'b0;
        tick();
        tick();
        if_cancel_in = 1'b1;
        tick();
        if_cancel_in = 1'b0;
        check("cancel_if_done", 32'(if_done_out), 32'd0);
        check("cancel_wr", 32'(mem_wr), 32'd0);
        check("cancel_inst", if_inst_out, inst_before);
        mem_req_in = 1'b1; mem_we_in = 1'b0; mem_addr_in = 32'h400; mem_width_in = 2'b00;
        tick();
        mem_req_in = 1'b0;
        check("cancel_grant_addr", mem_a, 32'h400);
        tick();
        check("cancel_mem_done_early", 32'(mem_done_out), 32'd0);
        tick();
        check("cancel_mem_done", 32'(mem_done_out), 32'd1);
        check("cancel_rdata", mem_rdata_out, 32'(sh_rd(32'h400)));
        check("cancel_if_done_late", 32'(if_done_out), 32'd0);
        tick();

        // Byte store to I/O while the UART buffer is full.
        io_buffer_full_in = 1'b1;
        mem_req_in = 1'b1; mem_we_in = 1'b1; mem_addr_in = 32'h0003_0000;
        mem_width_in = 2'b00; mem_wdata_in = 32'h0000_005A;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 0) mem_req_in = 1'b0;
            if (k == 2) io_buffer_full_in = 1'b0;
            check("io_wr", 32'(mem_wr), (k == 3) ? 32'd1 : 32'd0);
            check("io_done", 32'(mem_done_out), (k == 4) ? 32'd1 : 32'd0);
            if (k == 3) begin
                check("io_addr", mem_a, 32'h0003_0000);
                check("io_dout", 32'(mem_dout), 32'h5A);
            end
        end
        sh[32'h0003_0000] = 8'h5A;
        check("io_ram", 32'(ram_rd(32'h0003_0000)), 32'h5A);
        tick();

        // Reset in the middle of a word store.
        mem_req_in = 1'b1; mem_we_in = 1'b1; mem_addr_in = 32'h2000;
        mem_width_in = 2'b10; mem_wdata_in = 32'h1122_3344;
        tick();
        mem_req_in = 1'b0;
        tick();
        check("rst_mid_wr_before", 32'(mem_wr), 32'd1);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("rst_mid_wr", 32'(mem_wr), 32'd0);
        check("rst_mid_addr", mem_a, 32'd0);
        check("rst_mid_rdata", mem_rdata_out, 32'd0);
        check("rst_mid_inst", if_inst_out, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rst_after_wr", 32'(mem_wr), 32'd0);
            check("rst_after_done", 32'(mem_done_out), 32'd0);
        end
        sh[32'h2000] = 8'h44;
        sh[32'h2001] = 8'h33;

        // Randomized traffic with ready stalls, including address wrap.
        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 2);
            ra = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : 32'($urandom);
            xfer(kind == 0, kind == 2, ra, 2'($urandom_range(0, 3)), 32'($urandom), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
